// File: rtl/lcd_bus_receiver.sv
// rtl/lcd_bus_receiver.sv - HD44780-style LCD write-bus responder with line buffer and "0xHH" frame decode.
// Optional: define LCD_RX_LOWERCASE_HEX_EN to accept 'a'-'f' as hex digits.
module lcd_bus_receiver #(
  parameter int  DEPTH      = 16,
  parameter int  PREFIX_POS = 8,
  parameter int  HEX_HI_POS = 10,
  parameter int  HEX_LO_POS = 11,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    lcd_data,
  input  logic          lcd_rs,
  input  logic          lcd_rw,
  input  logic          lcd_en,
  output logic          busy,
  input  logic [AW-1:0] char_rd_addr,
  output logic [7:0]    char_rd_data,
  output logic [AW-1:0] cur_addr,
  output logic          frame_done,
  output logic [7:0]    byte_out,
  output logic          byte_valid,
  output logic          decode_err,
  output logic          proto_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_CHECK,
    S_DECODE,
    S_CLEAR
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW-1:0] PFX0_IDX = AW'(PREFIX_POS);
  localparam logic [AW-1:0] PFX1_IDX = AW'(PREFIX_POS + 1);
  localparam logic [AW-1:0] HI_IDX   = AW'(HEX_HI_POS);
  localparam logic [AW-1:0] LO_IDX   = AW'(HEX_LO_POS);

  state_t        state_q, state_d;
  logic [AW-1:0] cur_addr_q, cur_addr_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;
  logic [7:0]    cmd_data_q, cmd_data_d;
  logic          cmd_rs_q, cmd_rs_d;
  logic          cmd_rw_q, cmd_rw_d;
  logic          prefix_ok_q, prefix_ok_d;
  logic [7:0]    byte_out_q, byte_out_d;
  logic          frame_done_q, frame_done_d;
  logic          byte_valid_q, byte_valid_d;
  logic          decode_err_q, decode_err_d;
  logic          proto_err_q, proto_err_d;
  logic [7:0]    char_rd_data_q;

  logic          en_q, rs_q, rw_q, armed_q;
  logic [7:0]    data_q;
  logic          strobe;

  logic [7:0]    mem_q [DEPTH];
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [4:0]    hi_nib, lo_nib;

  // Bit 4 of the result flags a valid hex character; bits 3:0 carry the nibble.
  function automatic logic [4:0] hex_nib(input logic [7:0] c);
    logic [4:0] r;
    r = 5'h00;
    if (c >= 8'h30 && c <= 8'h39) begin
      r = {1'b1, c[3:0]};
    end else if (c >= 8'h41 && c <= 8'h46) begin
      r = {1'b1, c[3:0] + 4'd9};
    end
`ifdef LCD_RX_LOWERCASE_HEX_EN
    else if (c >= 8'h61 && c <= 8'h66) begin
      r = {1'b1, c[3:0] + 4'd9};
    end
`endif
    return r;
  endfunction

  assign hi_nib = hex_nib(mem_q[HI_IDX]);
  assign lo_nib = hex_nib(mem_q[LO_IDX]);

  // armed_q blocks a strobe from an EN level that was already high across reset.
  assign strobe = armed_q & en_q & ~lcd_en;

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    clr_idx_d    = clr_idx_q;
    cmd_data_d   = cmd_data_q;
    cmd_rs_d     = cmd_rs_q;
    cmd_rw_d     = cmd_rw_q;
    prefix_ok_d  = prefix_ok_q;
    byte_out_d   = byte_out_q;
    frame_done_d = 1'b0;
    byte_valid_d = 1'b0;
    decode_err_d = 1'b0;
    proto_err_d  = 1'b0;
    wr_en        = 1'b0;
    wr_addr      = cur_addr_q;
    wr_data      = cmd_data_q;

    if (strobe && state_q != S_IDLE) begin
      proto_err_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (strobe) begin
          cmd_data_d = data_q;
          cmd_rs_d   = rs_q;
          cmd_rw_d   = rw_q;
          state_d    = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_IDLE;
        if (cmd_rw_q) begin
          proto_err_d = 1'b1;
        end else if (cmd_rs_q) begin
          wr_en      = 1'b1;
          cur_addr_d = cur_addr_q + AW'(1);
          if (cur_addr_q == LAST_IDX) begin
            frame_done_d = 1'b1;
            state_d      = S_CHECK;
          end
        end else if (cmd_data_q == 8'h01) begin
          cur_addr_d = '0;
          clr_idx_d  = '0;
          state_d    = S_CLEAR;
        end else if (cmd_data_q == 8'h02) begin
          cur_addr_d = '0;
        end else if (cmd_data_q[7]) begin
          cur_addr_d = cmd_data_q[AW-1:0];
        end else begin
          proto_err_d = 1'b1;
        end
      end
      S_CHECK: begin
        prefix_ok_d = (mem_q[PFX0_IDX] == 8'h30) && (mem_q[PFX1_IDX] == 8'h78);
        state_d     = S_DECODE;
      end
      S_DECODE: begin
        if (prefix_ok_q && hi_nib[4] && lo_nib[4]) begin
          byte_out_d   = {hi_nib[3:0], lo_nib[3:0]};
          byte_valid_d = 1'b1;
        end else begin
          decode_err_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      S_CLEAR: begin
        wr_en     = 1'b1;
        wr_addr   = clr_idx_q;
        wr_data   = 8'h20;
        clr_idx_d = clr_idx_q + AW'(1);
        if (clr_idx_q == LAST_IDX) begin
          clr_idx_d = '0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_CLEAR;
      cur_addr_q     <= '0;
      clr_idx_q      <= '0;
      cmd_data_q     <= 8'h00;
      cmd_rs_q       <= 1'b0;
      cmd_rw_q       <= 1'b0;
      prefix_ok_q    <= 1'b0;
      byte_out_q     <= 8'h00;
      frame_done_q   <= 1'b0;
      byte_valid_q   <= 1'b0;
      decode_err_q   <= 1'b0;
      proto_err_q    <= 1'b0;
      char_rd_data_q <= 8'h00;
      en_q           <= 1'b0;
      rs_q           <= 1'b0;
      rw_q           <= 1'b0;
      data_q         <= 8'h00;
      armed_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cur_addr_q     <= cur_addr_d;
      clr_idx_q      <= clr_idx_d;
      cmd_data_q     <= cmd_data_d;
      cmd_rs_q       <= cmd_rs_d;
      cmd_rw_q       <= cmd_rw_d;
      prefix_ok_q    <= prefix_ok_d;
      byte_out_q     <= byte_out_d;
      frame_done_q   <= frame_done_d;
      byte_valid_q   <= byte_valid_d;
      decode_err_q   <= decode_err_d;
      proto_err_q    <= proto_err_d;
      char_rd_data_q <= mem_q[char_rd_addr];
      en_q           <= lcd_en;
      rs_q           <= lcd_rs;
      rw_q           <= lcd_rw;
      data_q         <= lcd_data;
      armed_q        <= armed_q | ~lcd_en;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign char_rd_data = char_rd_data_q;
  assign cur_addr     = cur_addr_q;
  assign frame_done   = frame_done_q;
  assign byte_out     = byte_out_q;
  assign byte_valid   = byte_valid_q;
  assign decode_err   = decode_err_q;
  assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// tb/tb_lcd_bus_receiver.sv - self-checking bench for lcd_bus_receiver against a cycle-indexed outcome model.
module tb_lcd_bus_receiver;

  localparam int MAXC  = 8192;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] lcd_data = 8'h00;
  logic       lcd_rs = 1'b0;
  logic       lcd_rw = 1'b0;
  logic       lcd_en = 1'b0;
  logic [3:0] char_rd_addr = 4'h0;
  logic       busy;
  logic [7:0] char_rd_data;
  logic [3:0] cur_addr;
  logic       frame_done;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       decode_err;
  logic       proto_err;

  always #5 clk = ~clk;

  lcd_bus_receiver dut (
    .clk          (clk),
    .rst          (rst),
    .lcd_data     (lcd_data),
    .lcd_rs       (lcd_rs),
    .lcd_rw       (lcd_rw),
    .lcd_en       (lcd_en),
    .busy         (busy),
    .char_rd_addr (char_rd_addr),
    .char_rd_data (char_rd_data),
    .cur_addr     (cur_addr),
    .frame_done   (frame_done),
    .byte_out     (byte_out),
    .byte_valid   (byte_valid),
    .decode_err   (decode_err),
    .proto_err    (proto_err)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Expected outputs indexed by the number of rising edges seen so far.
  bit         mbusy  [MAXC];
  bit         mframe [MAXC];
  bit         mvalid [MAXC];
  bit         mderr  [MAXC];
  bit         mperr  [MAXC];
  logic [3:0] maddr  [MAXC];
  logic [7:0] mbyte  [MAXC];
  logic [7:0] mbuf   [DEPTH];

  int passed = 0;
  int total  = 0;
  bit chk_on = 1'b0;
  int fd_seen = 0, bv_seen = 0, de_seen = 0, pe_seen = 0;

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act == want) passed++;
    else $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, want);
  endtask

  function automatic int hexval(input logic [7:0] c);
    string up;
    up = "0123456789ABCDEF";
    for (int i = 0; i < 16; i++) if (up[i] == c) return i;
`ifdef LCD_RX_LOWERCASE_HEX_EN
    begin
      string lo;
      lo = "abcdef";
      for (int i = 0; i < 6; i++) if (lo[i] == c) return 10 + i;
    end
`endif
    return -1;
  endfunction

  task automatic fwd_addr(input int from, input int v);
    for (int k = from; k < MAXC; k++) maddr[k] = 4'(v);
  endtask

  task automatic fwd_byte(input int from, input int v);
    for (int k = from; k < MAXC; k++) mbyte[k] = 8'(v);
  endtask

  task automatic model_reset(input int r);
    for (int k = r; k < MAXC; k++) begin
      mbusy[k]  = (k < r + DEPTH);
      mframe[k] = 1'b0;
      mvalid[k] = 1'b0;
      mderr[k]  = 1'b0;
      mperr[k]  = 1'b0;
      maddr[k]  = 4'h0;
      mbyte[k]  = 8'h00;
    end
    for (int i = 0; i < DEPTH; i++) mbuf[i] = 8'h20;
  endtask

  // Outcome of a strobe accepted at edge a.
  task automatic model_strobe(input int a, input bit rs, input bit rw, input logic [7:0] d);
    int old, hi, lo;
    if (mbusy[a-1]) begin
      mperr[a] = 1'b1;
      return;
    end
    mbusy[a] = 1'b1;
    if (rw) begin
      mperr[a+1] = 1'b1;
    end else if (rs) begin
      old = int'(maddr[a]);
      mbuf[old] = d;
      fwd_addr(a + 1, (old + 1) % DEPTH);
      if (old == DEPTH - 1) begin
        mframe[a+1] = 1'b1;
        mbusy[a+1]  = 1'b1;
        mbusy[a+2]  = 1'b1;
        hi = hexval(mbuf[10]);
        lo = hexval(mbuf[11]);
        if (mbuf[8] == 8'h30 && mbuf[9] == 8'h78 && hi >= 0 && lo >= 0) begin
          mvalid[a+3] = 1'b1;
          fwd_byte(a + 3, hi * 16 + lo);
        end else begin
          mderr[a+3] = 1'b1;
        end
      end
    end else if (d == 8'h01) begin
      fwd_addr(a + 1, 0);
      for (int k = a + 1; k <= a + DEPTH; k++) mbusy[k] = 1'b1;
      for (int i = 0; i < DEPTH; i++) mbuf[i] = 8'h20;
    end else if (d == 8'h02) begin
      fwd_addr(a + 1, 0);
    end else if (d >= 8'h80) begin
      fwd_addr(a + 1, d % DEPTH);
    end else begin
      mperr[a+1] = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    if (chk_on && cyc < MAXC) begin
      chk("busy", int'(busy), int'(mbusy[cyc]));
      chk("cur_addr", int'(cur_addr), int'(maddr[cyc]));
      chk("frame_done", int'(frame_done), int'(mframe[cyc]));
      chk("byte_valid", int'(byte_valid), int'(mvalid[cyc]));
      chk("decode_err", int'(decode_err), int'(mderr[cyc]));
      chk("proto_err", int'(proto_err), int'(mperr[cyc]));
      chk("byte_out", int'(byte_out), int'(mbyte[cyc]));
      if (frame_done) fd_seen++;
      if (byte_valid) bv_seen++;
      if (decode_err) de_seen++;
      if (proto_err)  pe_seen++;
    end
  end

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset(cyc + 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_on = 1'b1;
  endtask

  task automatic strobe(input bit rs, input bit rw, input logic [7:0] d, input int len);
    @(posedge clk);
    #1;
    lcd_en = 1'b1; lcd_rs = rs; lcd_rw = rw; lcd_data = d;
    repeat (len) @(posedge clk);
    #1;
    lcd_en = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data = 8'h00;
    model_strobe(cyc + 1, rs, rw, d);
  endtask

  task automatic write_frame(input string s);
    for (int i = 0; i < DEPTH; i++) begin
      strobe(1'b1, 1'b0, s[i], 1);
      repeat (6) @(posedge clk);
    end
  endtask

  task automatic read_one(input int idx, input logic [7:0] want);
    @(posedge clk);
    #1;
    char_rd_addr = 4'(idx);
    @(posedge clk);
    #1;
    chk($sformatf("rd_lit[%0d]", idx), int'(char_rd_data), int'(want));
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk);
      #1;
      char_rd_addr = 4'(i);
      @(posedge clk);
      #1;
      chk($sformatf("rd[%0d]", i), int'(char_rd_data), int'(mbuf[i]));
    end
  endtask

  initial begin
    #80000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $display("%0d/%0d checks passed", passed, total - 1 + 1);
    $finish;
  end

  initial begin
    int n, p0;
    do_reset();
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("busy_len_after_reset", n, 16);
    read_all();
    chk("cur_addr_after_reset", int'(cur_addr), 0);

    write_frame("Result: 0xA5    ");
    settle(10);
    chk("byte_out_A5", int'(byte_out), 8'hA5);
    chk("frame_done_count", fd_seen, 1);
    chk("byte_valid_count", bv_seen, 1);
    chk("decode_err_count", de_seen, 0);
    read_one(0, 8'h52);
    read_one(10, 8'h41);

    write_frame("Result: 0xAG    ");
    settle(10);
    chk("decode_err_G", de_seen, 1);
    chk("byte_out_hold", int'(byte_out), 8'hA5);

    write_frame("Result: 0xa5    ");
    settle(10);
`ifdef LCD_RX_LOWERCASE_HEX_EN
    chk("lower_valid", bv_seen, 2);
    chk("lower_err", de_seen, 1);
`else
    chk("lower_valid", bv_seen, 1);
    chk("lower_err", de_seen, 2);
`endif
    chk("byte_out_lower", int'(byte_out), 8'hA5);
    chk("frame_done_total", fd_seen, 3);

    strobe(1'b0, 1'b0, 8'h8A, 1);
    settle(4);
    strobe(1'b1, 1'b0, 8'h41, 1);
    settle(4);
    chk("cur_addr_11", int'(cur_addr), 11);
    read_one(10, 8'h41);

    strobe(1'b0, 1'b0, 8'h01, 1);
    settle(22);
    read_all();
    read_one(10, 8'h20);

    p0 = pe_seen;
    strobe(1'b0, 1'b0, 8'h38, 1);
    settle(4);
    chk("proto_unknown_cmd", pe_seen - p0, 1);
    strobe(1'b1, 1'b1, 8'h55, 1);
    settle(4);
    chk("proto_rw", pe_seen - p0, 2);
    strobe(1'b0, 1'b0, 8'h01, 1);
    strobe(1'b1, 1'b0, 8'h77, 1);
    settle(22);
    chk("proto_busy", pe_seen - p0, 3);
    read_all();

    strobe(1'b0, 1'b0, 8'h83, 1);
    settle(4);
    strobe(1'b1, 1'b0, 8'h33, 5);
    settle(4);
    chk("long_en_addr", int'(cur_addr), 4);
    read_one(3, 8'h33);
    read_all();

    strobe(1'b1, 1'b0, 8'h31, 1);
    settle(4);
    strobe(1'b0, 1'b0, 8'h02, 1);
    settle(4);
    chk("home_addr", int'(cur_addr), 0);

    p0 = fd_seen + bv_seen + de_seen + pe_seen;
    strobe(1'b0, 1'b0, 8'h01, 1);
    settle(5);
    do_reset();
    settle(22);
    chk("no_pulse_mid_clear_reset", fd_seen + bv_seen + de_seen + pe_seen, p0);
    read_all();

    @(posedge clk);
    #1;
    lcd_en = 1'b1; lcd_rs = 1'b1; lcd_data = 8'h41;
    do_reset();
    settle(20);
    lcd_en = 1'b0; lcd_rs = 1'b0; lcd_data = 8'h00;
    settle(6);
    chk("en_across_reset_addr", int'(cur_addr), 0);
    read_all();

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
